// File: rtl/r5_input_collector_pkg.sv
// Shared constants and types for the radix-5 input collector.
package r5_input_collector_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned RADIX  = 5;
  localparam int unsigned IDX_W  = $clog2(RADIX);

  // One complex sample at the default word width.
  typedef struct packed {
    logic [DW_DEF-1:0] re;
    logic [DW_DEF-1:0] img;
  } cplx_t;

  // True when idx addresses the last slot of a group.
  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(RADIX - 1);
  endfunction

endpackage

// File: rtl/r5_input_collector_bank.sv
// Five-entry complex register file: indexed write, parallel read, async clear.
module r5_bank
  import r5_input_collector_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [DW-1:0]             re_i,
  input  logic [DW-1:0]             img_i,
  output logic [RADIX-1:0][DW-1:0]  re_o,
  output logic [RADIX-1:0][DW-1:0]  img_o
);

  logic [RADIX-1:0][DW-1:0] re_q;
  logic [RADIX-1:0][DW-1:0] img_q;

  // Write the addressed slot; reset clears every slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q  <= '0;
      img_q <= '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < RADIX; i++) begin
        if (idx_i == IDX_W'(i)) begin
          re_q[i]  <= re_i;
          img_q[i] <= img_i;
        end
      end
    end
  end

  assign re_o  = re_q;
  assign img_o = img_q;

endmodule

// File: rtl/r5_input_collector.sv
// Serial-to-parallel radix-5 collector with ping-pong banks.
module r5_input_collector
  import r5_input_collector_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned N_GROUPS = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [DW-1:0]               in_re,
  input  logic [DW-1:0]               in_img,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               x0_re,
  output logic [DW-1:0]               x1_re,
  output logic [DW-1:0]               x2_re,
  output logic [DW-1:0]               x3_re,
  output logic [DW-1:0]               x4_re,
  output logic [DW-1:0]               x0_img,
  output logic [DW-1:0]               x1_img,
  output logic [DW-1:0]               x2_img,
  output logic [DW-1:0]               x3_img,
  output logic [DW-1:0]               x4_img,
  output logic                        out_last,
  output logic [$clog2(N_GROUPS)-1:0] grp_cnt,
  output logic                        sync_err
);

  localparam int unsigned     GW       = $clog2(N_GROUPS);
  localparam logic [GW-1:0]   LAST_GRP = GW'(N_GROUPS - 1);

  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [1:0]        full_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [GW-1:0]     wr_grp_q;
  logic [GW-1:0]     tag_q [2];
  logic              sync_err_q;

  logic              accept;
  logic              consume;
  logic              sof_acc;
  logic              grp_done;
  logic [IDX_W-1:0]  idx_eff;
  logic [GW-1:0]     grp_eff;

  logic [RADIX-1:0][DW-1:0] bank_re  [2];
  logic [RADIX-1:0][DW-1:0] bank_img [2];
  logic [RADIX-1:0][DW-1:0] rd_re;
  logic [RADIX-1:0][DW-1:0] rd_img;

  // Handshakes; an accepted SOF restarts both the slot index and the group count.
  always_comb begin
    in_ready  = ~full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    accept    = in_valid & in_ready;
    consume   = out_valid & out_ready;
    sof_acc   = accept & in_sof;
    idx_eff   = sof_acc ? '0 : wr_idx_q;
    grp_eff   = sof_acc ? '0 : wr_grp_q;
    grp_done  = accept & is_last_idx(idx_eff);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    r5_bank #(.DW(DW)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (accept & (wr_bank_q == 1'(b))),
      .idx_i (idx_eff),
      .re_i  (in_re),
      .img_i (in_img),
      .re_o  (bank_re[b]),
      .img_o (bank_img[b])
    );
  end

  // Pointer, full-flag, tag and error bookkeeping. Fill and drain always touch
  // different full bits because each side is gated by the flag it modifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      full_q     <= '0;
      wr_idx_q   <= '0;
      wr_grp_q   <= '0;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      if (accept) begin
        if (grp_done) begin
          full_q[wr_bank_q] <= 1'b1;
          tag_q[wr_bank_q]  <= grp_eff;
          wr_idx_q          <= '0;
          wr_bank_q         <= ~wr_bank_q;
          wr_grp_q          <= (grp_eff == LAST_GRP) ? '0 : grp_eff + GW'(1);
        end else begin
          wr_idx_q <= idx_eff + IDX_W'(1);
          wr_grp_q <= grp_eff;
        end
        if (sof_acc && (wr_idx_q != '0)) begin
          sync_err_q <= 1'b1;
        end
      end
      if (consume) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
    end
  end

  // Present the read bank.
  always_comb begin
    rd_re    = rd_bank_q ? bank_re[1]  : bank_re[0];
    rd_img   = rd_bank_q ? bank_img[1] : bank_img[0];
    grp_cnt  = tag_q[rd_bank_q];
    out_last = out_valid & (tag_q[rd_bank_q] == LAST_GRP);
    sync_err = sync_err_q;
  end

  assign x0_re  = rd_re[0];
  assign x1_re  = rd_re[1];
  assign x2_re  = rd_re[2];
  assign x3_re  = rd_re[3];
  assign x4_re  = rd_re[4];
  assign x0_img = rd_img[0];
  assign x1_img = rd_img[1];
  assign x2_img = rd_img[2];
  assign x3_img = rd_img[3];
  assign x4_img = rd_img[4];

endmodule

// File: tb/tb_r5_input_collector.sv
// Scoreboard bench for r5_input_collector: directed streams, monitor on consume.
module tb_r5_input_collector;

  typedef struct packed {
    logic [4:0][31:0] re;
    logic [4:0][31:0] img;
    logic [2:0]       grp;
    logic             last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [31:0] in_re;
  logic [31:0] in_img;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x0_re, x1_re, x2_re, x3_re, x4_re;
  logic [31:0] x0_img, x1_img, x2_img, x3_img, x4_img;
  logic        out_last;
  logic [2:0]  grp_cnt;
  logic        sync_err;

  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  r5_input_collector #(.DW(32), .N_GROUPS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_re(in_re), .in_img(in_img),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_re(x0_re), .x1_re(x1_re), .x2_re(x2_re), .x3_re(x3_re), .x4_re(x4_re),
    .x0_img(x0_img), .x1_img(x1_img), .x2_img(x2_img), .x3_img(x3_img), .x4_img(x4_img),
    .out_last(out_last), .grp_cnt(grp_cnt), .sync_err(sync_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Group of five samples re=base+i, img=-(base+i), tagged grp.
  function automatic exp_t mk(input int base, input int grp);
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.re[i]  = 32'(base + i);
      e.img[i] = 32'(-(base + i));
    end
    e.grp  = 3'(grp);
    e.last = (grp == 4);
    return e;
  endfunction

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input int v, input bit sof);
    int waited = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = 32'(v);
    in_img   = 32'(-v);
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      stall_cnt++;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 64'(v), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    in_sof = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compare each group at the moment it is consumed.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t act;
      exp_t e;
      act.re   = {x4_re, x3_re, x2_re, x1_re, x0_re};
      act.img  = {x4_img, x3_img, x2_img, x1_img, x0_img};
      act.grp  = grp_cnt;
      act.last = out_last;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_group: got %h expected none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL group: got %h expected %h", act, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_re = '0; in_img = '0; out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_grp_last",  {62'd0, grp_cnt == 3'd0, out_last}, {62'd0, 1'b1, 1'b0});
    chk("rst_sync_err",  64'(sync_err),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2: single group with SOF, latency
    out_ready = 1'b1;
    exp_q.push_back(mk(1, 0));
    send(1, 1'b1);
    for (int k = 2; k <= 4; k++) send(k, 1'b0);
    chk("t2_not_yet_valid", 64'(out_valid), 64'd0);
    send(5, 1'b0);
    in_valid = 1'b0;
    chk("t2_valid_after_5th", 64'(out_valid), 64'd1);
    chk("t2_x4_img", 64'(x4_img), 64'hFFFF_FFFB);
    drain("t2_drain");

    // T3: a full frame of 25 samples back-to-back
    stall_cnt = 0;
    for (int g = 0; g < 5; g++) exp_q.push_back(mk(100 + 5 * g, g));
    for (int k = 0; k < 25; k++) send(100 + k, k == 0);
    in_valid = 1'b0;
    chk("t3_no_stall", 64'(stall_cnt), 64'd0);
    drain("t3_drain");
    chk("t3_sync_err_clean", 64'(sync_err), 64'd0);

    // T4: backpressure fills both banks
    out_ready = 1'b0;
    exp_q.push_back(mk(200, 0));
    exp_q.push_back(mk(205, 1));
    exp_q.push_back(mk(210, 2));
    for (int k = 0; k < 10; k++) send(200 + k, 1'b0);
    chk("t4_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_re = 32'd210; in_img = 32'(-210);
    repeat (3) begin @(posedge clk); #1; end
    chk("t4_x0_held", 64'(x0_re), 64'd200);
    chk("t4_still_blocked", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_reopen", 64'(in_ready), 64'd1);
    chk("t4_second_group", {32'(x0_re), 32'(grp_cnt)}, {32'd205, 32'd1});
    for (int k = 210; k < 215; k++) send(k, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("t4_drain");

    // T5: SOF inside a group discards the partial group
    exp_q.push_back(mk(302, 0));
    send(300, 1'b0);
    send(301, 1'b0);
    send(302, 1'b1);
    chk("t5_sync_err_set", 64'(sync_err), 64'd1);
    for (int k = 303; k < 307; k++) send(k, 1'b0);
    in_valid = 1'b0;
    drain("t5_drain");
    chk("t5_sync_err_sticky", 64'(sync_err), 64'd1);

    // T6: completion and consume in the same cycle
    out_ready = 1'b0;
    exp_q.push_back(mk(400, 1));
    exp_q.push_back(mk(405, 2));
    for (int k = 400; k < 409; k++) send(k, 1'b0);
    out_ready = 1'b1;
    send(409, 1'b0);
    in_valid = 1'b0;
    chk("t6_no_bubble", {32'(out_valid), 32'(x0_re)}, {32'd1, 32'd405});
    drain("t6_drain");

    // T1: asynchronous reset during a stall with a partial group open
    out_ready = 1'b0;
    for (int k = 500; k < 507; k++) send(k, 1'b0);
    in_valid = 1'b0;
    chk("t1_pending", {32'(out_valid), 32'(x0_re)}, {32'd1, 32'd500});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    chk("t1_x_cleared", {32'(x0_re), 32'(x4_img)}, 64'd0);
    chk("t1_sync_err", 64'(sync_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(mk(600, 0));
    for (int k = 600; k < 605; k++) send(k, 1'b0);
    in_valid = 1'b0;
    drain("t1_post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
